// File: rtl/motor_pingroup_sync.sv
// Motor pin group: synchronised/debounced driver inputs, registered driver outputs.
// Optional per-motor fault latch built when MOTOR_PINGROUP_FAULT_LATCH_EN is defined.

package motor_pingroup_pkg;
  typedef struct packed {
    logic StepBOOST_o;
    logic StepDIR_o;
    logic StepDeactivate_o;
    logic StepOutP_o;
  } mcoutput_t;

  typedef struct packed {
    logic       OH_i;
    logic       StepPFail_i;
    logic [1:0] RawSwitches_b2;
  } mcinput_t;
endpackage

module motor_pingroup_sync
  import motor_pingroup_pkg::*;
#(
  parameter int unsigned NUM_MOTORS      = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [1:NUM_MOTORS]   pl_fail,
  input  logic [1:NUM_MOTORS]   pl_sw_outa,
  input  logic [1:NUM_MOTORS]   pl_sw_outb,
  output logic [1:NUM_MOTORS]   pl_boost,
  output logic [1:NUM_MOTORS]   pl_dir,
  output logic [1:NUM_MOTORS]   pl_en,
  output logic [1:NUM_MOTORS]   pl_clk,
  input  mcoutput_t [NUM_MOTORS:1] motorControl,
  output mcinput_t  [NUM_MOTORS:1] motorStatus,
  input  logic [1:NUM_MOTORS]   fault_clr_i,
  output logic [1:NUM_MOTORS]   fault_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:NUM_MOTORS] f_fail, f_swa, f_swb;
  logic [1:NUM_MOTORS] fault_n;
  logic [1:NUM_MOTORS] boost_d, dir_d, en_d, clk_d;
  logic [1:NUM_MOTORS] boost_q, dir_q, en_q, clk_q;

  for (genvar m = 1; m <= NUM_MOTORS; m++) begin : g_motor
    logic [2:0] pin_raw;
    logic [2:0] filt;

    assign pin_raw = {pl_sw_outb[m], pl_sw_outa[m], pl_fail[m]};

    for (genvar b = 0; b < 3; b++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic                   filt_q, filt_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   s;

      assign s = sync_q[SYNC_STAGES-1];

      // Counter only runs while the synchronised bit disagrees with the filtered
      // state, so any bounce back to the old level restarts the count from zero.
      always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_raw[b]};
        filt_d = filt_q;
        cnt_d  = '0;
        if (s != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            filt_d = s;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          sync_q <= '0;
          filt_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          sync_q <= sync_d;
          filt_q <= filt_d;
          cnt_q  <= cnt_d;
        end
      end

      assign filt[b] = filt_q;
    end

    assign f_fail[m] = filt[0];
    assign f_swa[m]  = filt[1];
    assign f_swb[m]  = filt[2];

    assign motorStatus[m].OH_i           = 1'b0;
    assign motorStatus[m].StepPFail_i    = f_fail[m];
    assign motorStatus[m].RawSwitches_b2 = {f_swb[m], f_swa[m]};

    // A faulted driver is parked: enable deasserted, no step pulses, no boost.
    assign boost_d[m] = motorControl[m].StepBOOST_o & ~fault_n[m];
    assign dir_d[m]   = motorControl[m].StepDIR_o;
    assign en_d[m]    = motorControl[m].StepDeactivate_o | fault_n[m];
    assign clk_d[m]   = motorControl[m].StepOutP_o & ~fault_n[m];
  end

`ifdef MOTOR_PINGROUP_FAULT_LATCH_EN
  logic [1:NUM_MOTORS] fault_q;

  assign fault_n = f_fail | (fault_q & ~fault_clr_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fault_q <= '0;
    end else begin
      fault_q <= fault_n;
    end
  end

  assign fault_o = fault_q;
`else
  logic unused_fault_clr;

  assign unused_fault_clr = ^fault_clr_i;
  assign fault_n          = '0;
  assign fault_o          = '0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      boost_q <= '0;
      dir_q   <= '0;
      en_q    <= '1;
      clk_q   <= '0;
    end else begin
      boost_q <= boost_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      clk_q   <= clk_d;
    end
  end

  assign pl_boost = boost_q;
  assign pl_dir   = dir_q;
  assign pl_en    = en_q;
  assign pl_clk   = clk_q;

endmodule

// File: tb/tb_motor_pingroup_sync.sv
// Directed bench for motor_pingroup_sync (NUM_MOTORS=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=8).
// Fault expectations follow MOTOR_PINGROUP_FAULT_LATCH_EN as compiled.
module tb_motor_pingroup_sync;
  import motor_pingroup_pkg::*;

  localparam int unsigned N = 8;
  localparam bit FLE =
`ifdef MOTOR_PINGROUP_FAULT_LATCH_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic [1:N] pl_fail, swa, swb, clr;
  logic [1:N] boost, dir, en, pclk, fault;
  mcoutput_t [N:1] ctrl;
  mcinput_t  [N:1] st;

  int n_tests = 0;
  int n_fail  = 0;

  mcinput_t [N:1] exp_st;
  logic exp_fault, exp_clk, exp_pclk, exp_boost;
  logic [1:N] ev;

  always #5 clk = ~clk;

  motor_pingroup_sync #(
    .NUM_MOTORS(N),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .pl_fail(pl_fail),
    .pl_sw_outa(swa),
    .pl_sw_outb(swb),
    .pl_boost(boost),
    .pl_dir(dir),
    .pl_en(en),
    .pl_clk(pclk),
    .motorControl(ctrl),
    .motorStatus(st),
    .fault_clr_i(clr),
    .fault_o(fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check(tag, 64'(st), 64'(exp_st));
  endtask

  task automatic check_reset_pins(input string tag);
    ev = '1;
    check({tag, "/en"}, 64'(en), 64'(ev));
    ev = '0;
    check({tag, "/clk"}, 64'(pclk), 64'(ev));
    check({tag, "/boost"}, 64'(boost), 64'(ev));
    check({tag, "/dir"}, 64'(dir), 64'(ev));
    check({tag, "/fault"}, 64'(fault), 64'(ev));
  endtask

  // Motor 1 runs with boost=1, dir=1, deactivate=0; step pulse toggles every cycle.
  task automatic step_m1(input string tag);
    ctrl[1].StepOutP_o = ~ctrl[1].StepOutP_o;
    exp_clk   = ctrl[1].StepOutP_o;
    exp_pclk  = exp_clk & ~exp_fault;
    exp_boost = ~exp_fault;
    tick();
    check({tag, "/fault"}, 64'(fault[1]), 64'(exp_fault));
    check({tag, "/en"}, 64'(en[1]), 64'(exp_fault));
    check({tag, "/clk"}, 64'(pclk[1]), 64'(exp_pclk));
    check({tag, "/boost"}, 64'(boost[1]), 64'(exp_boost));
    check({tag, "/dir"}, 64'(dir[1]), 64'(1'b1));
    check_status({tag, "/status"});
  endtask

  initial begin
    rstn      = 1'b0;
    pl_fail   = '0;
    swa       = '0;
    swb       = '0;
    clr       = '0;
    ctrl      = '0;
    exp_st    = '0;
    exp_fault = 1'b0;

    // Reset values hold even though the controller asks for enable.
    #12;
    check_reset_pins("rst");
    check_status("rst/status");

    for (int i = 1; i <= int'(N); i++) ctrl[i].StepDeactivate_o = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) tick();
    check_reset_pins("idle");
    check_status("idle/status");

    // Control to pin, one cycle.
    ctrl[4] = '{StepBOOST_o: 1'b1, StepDIR_o: 1'b1, StepDeactivate_o: 1'b0, StepOutP_o: 1'b1};
    tick();
    ev = '1; ev[4] = 1'b0;
    check("c2p/en", 64'(en), 64'(ev));
    ev = '0; ev[4] = 1'b1;
    check("c2p/boost", 64'(boost), 64'(ev));
    check("c2p/dir", 64'(dir), 64'(ev));
    check("c2p/clk", 64'(pclk), 64'(ev));
    ctrl[4] = '{StepBOOST_o: 1'b0, StepDIR_o: 1'b0, StepDeactivate_o: 1'b1, StepOutP_o: 1'b0};
    tick();
    check_reset_pins("c2p_back");

    // Clean edge on switch A of motor 3: 10 cycles to status.
    swa[3] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_status("swa3_wait");
    end
    tick();
    exp_st[3].RawSwitches_b2[0] = 1'b1;
    check_status("swa3_rise");

    // 7-cycle glitch on switch B of motor 5 is rejected.
    swb[5] = 1'b1;
    repeat (7) begin tick(); check_status("swb5_glitch_hi"); end
    swb[5] = 1'b0;
    repeat (12) begin tick(); check_status("swb5_glitch_lo"); end

    // 7 high, 1 low, then high: count restarts at the final rising edge.
    swb[5] = 1'b1;
    repeat (7) begin tick(); check_status("swb5_pat_hi7"); end
    swb[5] = 1'b0;
    tick();
    check_status("swb5_pat_lo1");
    swb[5] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_status("swb5_pat_wait");
    end
    tick();
    exp_st[5].RawSwitches_b2[1] = 1'b1;
    check_status("swb5_pat_rise");

    // Fault path on motor 1.
    ctrl[1] = '{StepBOOST_o: 1'b1, StepDIR_o: 1'b1, StepDeactivate_o: 1'b0, StepOutP_o: 1'b0};
    tick();
    step_m1("m1_run");
    step_m1("m1_run");
    pl_fail[1] = 1'b1;
    for (int i = 1; i <= 9; i++) step_m1("fail_deb");
    exp_st[1].StepPFail_i = 1'b1;
    step_m1("fail_seen");
    exp_fault = FLE;
    step_m1("fail_forced");
    repeat (3) step_m1("fault_hold");
    clr[1] = 1'b1;
    step_m1("clr_ignored");
    clr[1]     = 1'b0;
    pl_fail[1] = 1'b0;
    for (int i = 1; i <= 9; i++) step_m1("fail_fall_deb");
    exp_st[1].StepPFail_i = 1'b0;
    step_m1("fail_fell");
    repeat (2) step_m1("fault_latched");
    clr[1]    = 1'b1;
    exp_fault = 1'b0;
    step_m1("clr");
    clr[1] = 1'b0;
    repeat (2) step_m1("resume");

    // Reset at debounce count 5 of 8 on switch A of motor 2.
    swa[2] = 1'b1;
    repeat (7) begin tick(); check_status("swa2_pre"); end
    #1;
    rstn = 1'b0;
    #1;
    exp_st = '0;
    check_reset_pins("mid_rst");
    check_status("mid_rst/status");
    tick();
    check_reset_pins("mid_rst_hold");
    check_status("mid_rst_hold/status");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_status("post_rst_wait");
    end
    tick();
    exp_st[2].RawSwitches_b2[0] = 1'b1;
    exp_st[3].RawSwitches_b2[0] = 1'b1;
    exp_st[5].RawSwitches_b2[1] = 1'b1;
    check_status("post_rst_rise");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
